// File: rtl/commit_writeback_if.sv
// Commit-side and writeback-side signal bundle for commit_writeback.
interface commit_writeback_if #(
  parameter int NUM_REQS    = 2,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_BITS   = 44
);
  logic [NUM_REQS-1:0]             cmt_valid;
  logic [NUM_REQS-1:0]             cmt_ready;
  logic [NUM_REQS*UUID_BITS-1:0]   cmt_uuid;
  logic [NUM_REQS*NW_BITS-1:0]     cmt_wid;
  logic [NUM_REQS*NUM_THREADS-1:0] cmt_tmask;
  logic [NUM_REQS*32-1:0]          cmt_PC;
  logic [NUM_REQS*NR_BITS-1:0]     cmt_rd;
  logic [NUM_REQS-1:0]             cmt_wb;
  logic [NUM_REQS-1:0]             cmt_eop;
  logic [NUM_REQS*NUM_THREADS*32-1:0] cmt_data;

  logic                     wb_valid;
  logic                     wb_ready;
  logic [UUID_BITS-1:0]     wb_uuid;
  logic [NW_BITS-1:0]       wb_wid;
  logic [NUM_THREADS-1:0]   wb_tmask;
  logic [31:0]              wb_PC;
  logic [NR_BITS-1:0]       wb_rd;
  logic [NUM_THREADS*32-1:0] wb_data;
  logic                     wb_eop;

  modport slave (
    input  cmt_valid, cmt_uuid, cmt_wid, cmt_tmask, cmt_PC, cmt_rd, cmt_wb, cmt_eop, cmt_data,
    output cmt_ready,
    output wb_valid, wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop,
    input  wb_ready
  );

  modport master (
    output cmt_valid, cmt_uuid, cmt_wid, cmt_tmask, cmt_PC, cmt_rd, cmt_wb, cmt_eop, cmt_data,
    input  cmt_ready,
    input  wb_valid, wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop,
    output wb_ready
  );
endinterface

// File: rtl/commit_writeback.sv
// Round-robin commit arbiter feeding one registered writeback stage (1 cycle accept->wb_valid).
// A stalled writeback (wb_valid & ~wb_ready) blocks every source, including no-writeback commits.
module commit_writeback #(
  parameter int NUM_REQS    = 2,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_BITS   = 44
) (
  input  logic                 clk,
  input  logic                 reset,
  commit_writeback_if.slave    cw,
  output logic [63:0]          retired
);

  localparam int PTR_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int DATA_W = NUM_THREADS * 32;

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [UUID_BITS-1:0]   wb_uuid_q, wb_uuid_d;
  logic [NW_BITS-1:0]     wb_wid_q, wb_wid_d;
  logic [NUM_THREADS-1:0] wb_tmask_q, wb_tmask_d;
  logic [31:0]            wb_pc_q, wb_pc_d;
  logic [NR_BITS-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]      wb_data_q, wb_data_d;
  logic                   wb_eop_q, wb_eop_d;
  logic [63:0]            retired_q, retired_d;

  logic                   any_valid;
  logic [PTR_W-1:0]       winner;
  logic [PTR_W-1:0]       idx;
  logic                   stage_free;
  logic                   accept;
  logic [NUM_REQS-1:0]    ready;

  assign stage_free = ~wb_valid_q | cw.wb_ready;
  // No grants while reset is held so nothing is consumed and then lost.
  assign accept     = reset & any_valid & stage_free;

  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_REQS);
      if (!any_valid && cw.cmt_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (accept) begin
      ready[winner] = 1'b1;
    end
  end

  assign cw.cmt_ready = ready;

  always_comb begin
    ptr_d      = ptr_q;
    wb_valid_d = wb_valid_q & ~cw.wb_ready;
    wb_uuid_d  = wb_uuid_q;
    wb_wid_d   = wb_wid_q;
    wb_tmask_d = wb_tmask_q;
    wb_pc_d    = wb_pc_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_eop_d   = wb_eop_q;
    retired_d  = retired_q;
    if (accept) begin
      ptr_d = (winner == PTR_W'(NUM_REQS - 1)) ? '0 : winner + PTR_W'(1);
      if (cw.cmt_wb[winner]) begin
        wb_valid_d = 1'b1;
        wb_uuid_d  = cw.cmt_uuid[int'(winner)*UUID_BITS +: UUID_BITS];
        wb_wid_d   = cw.cmt_wid[int'(winner)*NW_BITS +: NW_BITS];
        wb_tmask_d = cw.cmt_tmask[int'(winner)*NUM_THREADS +: NUM_THREADS];
        wb_pc_d    = cw.cmt_PC[int'(winner)*32 +: 32];
        wb_rd_d    = cw.cmt_rd[int'(winner)*NR_BITS +: NR_BITS];
        wb_data_d  = cw.cmt_data[int'(winner)*DATA_W +: DATA_W];
        wb_eop_d   = cw.cmt_eop[winner];
      end
      // Retirement counts end-of-packet commits whether or not they write back.
      if (cw.cmt_eop[winner]) begin
        retired_d = retired_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_uuid_q  <= '0;
      wb_wid_q   <= '0;
      wb_tmask_q <= '0;
      wb_pc_q    <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_eop_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_uuid_q  <= wb_uuid_d;
      wb_wid_q   <= wb_wid_d;
      wb_tmask_q <= wb_tmask_d;
      wb_pc_q    <= wb_pc_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_eop_q   <= wb_eop_d;
      retired_q  <= retired_d;
    end
  end

  assign cw.wb_valid = wb_valid_q;
  assign cw.wb_uuid  = wb_uuid_q;
  assign cw.wb_wid   = wb_wid_q;
  assign cw.wb_tmask = wb_tmask_q;
  assign cw.wb_PC    = wb_pc_q;
  assign cw.wb_rd    = wb_rd_q;
  assign cw.wb_data  = wb_data_q;
  assign cw.wb_eop   = wb_eop_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_commit_writeback.sv
// Directed bench for commit_writeback: arbitration order, stalls, retire counting, reset.
module tb_commit_writeback;

  logic        clk;
  logic        reset;
  logic [63:0] retired;
  int          total;
  int          bad;
  logic [63:0] exp_ret;

  commit_writeback_if cw ();

  commit_writeback dut (
    .clk     (clk),
    .reset   (reset),
    .cw      (cw),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Source stimulus: wid is taken from rd[1:0], uuid is {rd, pc}.
  task automatic drive(input int s, input logic v, input logic wb, input logic eop,
                       input logic [5:0] rd, input logic [3:0] tm,
                       input logic [127:0] d, input logic [31:0] pc);
    cw.cmt_valid[s]           = v;
    cw.cmt_wb[s]              = wb;
    cw.cmt_eop[s]             = eop;
    cw.cmt_rd[s*6 +: 6]       = rd;
    cw.cmt_wid[s*2 +: 2]      = rd[1:0];
    cw.cmt_tmask[s*4 +: 4]    = tm;
    cw.cmt_data[s*128 +: 128] = d;
    cw.cmt_PC[s*32 +: 32]     = pc;
    cw.cmt_uuid[s*44 +: 44]   = {12'(rd), pc};
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    cw.cmt_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (cw.wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b exp=0", cw.wb_valid); end
    total++; if (cw.wb_data !== 128'd0) begin bad++; $display("FAIL rst_wb_data got=%h exp=0", cw.wb_data); end
    total++; if (cw.wb_rd !== 6'd0) begin bad++; $display("FAIL rst_wb_rd got=%0d exp=0", cw.wb_rd); end
    total++; if (retired !== 64'd0) begin bad++; $display("FAIL rst_retired got=%0d exp=0", retired); end
    total++; if (cw.cmt_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", cw.cmt_ready); end
    cw.cmt_valid = 2'b00;
    reset = 1'b1;
    exp_ret = 64'd0;
  endtask

  task automatic test_single();
    logic [127:0] d;
    d = {32'd1, 32'd2, 32'd3, 32'd4};
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 6'd5, 4'b1011, d, 32'h100);
    #1;
    total++; if (cw.cmt_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", cw.cmt_ready); end
    @(negedge clk);
    cw.cmt_valid[0] = 1'b0;
    exp_ret = exp_ret + 64'd1;
    #1;
    total++; if (cw.wb_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", cw.wb_valid); end
    total++; if (cw.wb_uuid !== {12'd5, 32'h100}) begin bad++; $display("FAIL single_uuid got=%h exp=%h", cw.wb_uuid, {12'd5, 32'h100}); end
    total++; if (cw.wb_wid !== 2'd1) begin bad++; $display("FAIL single_wid got=%0d exp=1", cw.wb_wid); end
    total++; if (cw.wb_tmask !== 4'b1011) begin bad++; $display("FAIL single_tmask got=%b exp=1011", cw.wb_tmask); end
    total++; if (cw.wb_PC !== 32'h100) begin bad++; $display("FAIL single_pc got=%h exp=100", cw.wb_PC); end
    total++; if (cw.wb_rd !== 6'd5) begin bad++; $display("FAIL single_rd got=%0d exp=5", cw.wb_rd); end
    total++; if (cw.wb_data !== d) begin bad++; $display("FAIL single_data got=%h exp=%h", cw.wb_data, d); end
    total++; if (cw.wb_eop !== 1'b1) begin bad++; $display("FAIL single_eop got=%b exp=1", cw.wb_eop); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL single_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  // Pointer is 1 here, so src1 wins and the pointer returns to 0.
  task automatic test_no_wb();
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 1'b1, 6'd30, 4'hF, 128'h0, 32'h200);
    #1;
    total++; if (cw.cmt_ready !== 2'b10) begin bad++; $display("FAIL nowb_ready got=%b exp=10", cw.cmt_ready); end
    @(negedge clk);
    cw.cmt_valid[1] = 1'b0;
    exp_ret = exp_ret + 64'd1;
    #1;
    total++; if (cw.wb_valid !== 1'b0) begin bad++; $display("FAIL nowb_valid got=%b exp=0", cw.wb_valid); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL nowb_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    logic [5:0] exp_rd;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 6'd10, 4'hF, {4{32'hA0A0_0000}}, 32'h300);
    drive(1, 1'b1, 1'b1, 1'b1, 6'd20, 4'hF, {4{32'hB0B0_0000}}, 32'h400);
    for (int c = 0; c < 4; c++) begin
      exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_rd  = (c % 2 == 0) ? 6'd20 : 6'd10;
      #1;
      total++; if (cw.cmt_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready_%0d got=%b exp=%b", c, cw.cmt_ready, exp_rdy); end
      if (c > 0) begin
        total++; if (cw.wb_valid !== 1'b1 || cw.wb_rd !== exp_rd) begin bad++; $display("FAIL rr_beat_%0d got=%b/%0d exp=1/%0d", c, cw.wb_valid, cw.wb_rd, exp_rd); end
      end
      @(negedge clk);
    end
    cw.cmt_valid = 2'b00;
    exp_ret = exp_ret + 64'd4;
    #1;
    total++; if (cw.wb_valid !== 1'b1 || cw.wb_rd !== 6'd20) begin bad++; $display("FAIL rr_last got=%b/%0d exp=1/20", cw.wb_valid, cw.wb_rd); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL rr_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 6'd9, 4'b0000, {4{32'hABAB_ABAB}}, 32'h500);
    #1;
    total++; if (cw.cmt_ready !== 2'b01) begin bad++; $display("FAIL mid_ready got=%b exp=01", cw.cmt_ready); end
    @(negedge clk);
    cw.cmt_valid[0] = 1'b0;
    exp_ret = exp_ret + 64'd1;
    #1;
    total++; if (cw.wb_valid !== 1'b1 || cw.wb_tmask !== 4'b0000) begin bad++; $display("FAIL mid_zero_tmask got=%b/%b exp=1/0000", cw.wb_valid, cw.wb_tmask); end
    total++; if (retired !== 64'd7) begin bad++; $display("FAIL mid_retired7 got=%0d exp=7", retired); end
    reset = 1'b0;
    cw.wb_ready = 1'b0;
    drive(1, 1'b1, 1'b1, 1'b1, 6'd17, 4'b0110, {4{32'h1717_1717}}, 32'h600);
    #1;
    total++; if (cw.cmt_ready !== 2'b00) begin bad++; $display("FAIL mid_rst_ready got=%b exp=00", cw.cmt_ready); end
    @(negedge clk);
    #1;
    total++; if (cw.wb_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", cw.wb_valid); end
    total++; if (retired !== 64'd0) begin bad++; $display("FAIL mid_rst_retired got=%0d exp=0", retired); end
    total++; if (cw.cmt_ready !== 2'b00) begin bad++; $display("FAIL mid_rst_ready2 got=%b exp=00", cw.cmt_ready); end
    reset = 1'b1;
    cw.wb_ready = 1'b1;
    #1;
    total++; if (cw.cmt_ready !== 2'b10) begin bad++; $display("FAIL mid_rel_ready got=%b exp=10", cw.cmt_ready); end
    @(negedge clk);
    cw.cmt_valid[1] = 1'b0;
    exp_ret = 64'd1;
    #1;
    total++; if (cw.wb_valid !== 1'b1 || cw.wb_rd !== 6'd17) begin bad++; $display("FAIL mid_rel_beat got=%b/%0d exp=1/17", cw.wb_valid, cw.wb_rd); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL mid_rel_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_stall();
    logic [127:0] d0;
    d0 = {32'h7000_0003, 32'h7000_0002, 32'h7000_0001, 32'h7000_0000};
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 6'd7, 4'hF, d0, 32'h700);
    #1;
    total++; if (cw.cmt_ready !== 2'b01) begin bad++; $display("FAIL stall_first_ready got=%b exp=01", cw.cmt_ready); end
    @(negedge clk);
    cw.cmt_valid[0] = 1'b0;
    cw.wb_ready = 1'b0;
    drive(1, 1'b1, 1'b1, 1'b0, 6'd21, 4'b0011, {4{32'h2121_2121}}, 32'h800);
    exp_ret = exp_ret + 64'd1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (cw.cmt_ready !== 2'b00) begin bad++; $display("FAIL stall_ready_%0d got=%b exp=00", c, cw.cmt_ready); end
      total++; if (cw.wb_valid !== 1'b1 || cw.wb_rd !== 6'd7 || cw.wb_data !== d0) begin bad++; $display("FAIL stall_hold_%0d got=%b/%0d/%h exp=1/7/%h", c, cw.wb_valid, cw.wb_rd, cw.wb_data, d0); end
      @(negedge clk);
    end
    cw.wb_ready = 1'b1;
    #1;
    total++; if (cw.cmt_ready !== 2'b10) begin bad++; $display("FAIL stall_release_ready got=%b exp=10", cw.cmt_ready); end
    @(negedge clk);
    cw.cmt_valid[1] = 1'b0;
    #1;
    total++; if (cw.wb_valid !== 1'b1 || cw.wb_rd !== 6'd21 || cw.wb_tmask !== 4'b0011 || cw.wb_eop !== 1'b0) begin bad++; $display("FAIL stall_next got=%b/%0d/%b/%b exp=1/21/0011/0", cw.wb_valid, cw.wb_rd, cw.wb_tmask, cw.wb_eop); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL stall_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_eop();
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 6'd3, 4'hF, {4{32'h0303_0303}}, 32'h900);
    #1;
    total++; if (cw.cmt_ready !== 2'b01) begin bad++; $display("FAIL eop_ready_a got=%b exp=01", cw.cmt_ready); end
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 6'd4, 4'hF, {4{32'h0404_0404}}, 32'hA00);
    #1;
    total++; if (cw.cmt_ready !== 2'b01) begin bad++; $display("FAIL eop_ready_b got=%b exp=01", cw.cmt_ready); end
    total++; if (cw.wb_valid !== 1'b1 || cw.wb_rd !== 6'd3 || cw.wb_eop !== 1'b0) begin bad++; $display("FAIL eop_beat_a got=%b/%0d/%b exp=1/3/0", cw.wb_valid, cw.wb_rd, cw.wb_eop); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL eop_retired_a got=%0d exp=%0d", retired, exp_ret); end
    @(negedge clk);
    cw.cmt_valid[0] = 1'b0;
    exp_ret = exp_ret + 64'd1;
    #1;
    total++; if (cw.wb_valid !== 1'b1 || cw.wb_rd !== 6'd4 || cw.wb_eop !== 1'b1) begin bad++; $display("FAIL eop_beat_b got=%b/%0d/%b exp=1/4/1", cw.wb_valid, cw.wb_rd, cw.wb_eop); end
    total++; if (retired !== exp_ret) begin bad++; $display("FAIL eop_retired_b got=%0d exp=%0d", retired, exp_ret); end
    @(negedge clk);
    #1;
    total++; if (cw.wb_valid !== 1'b0) begin bad++; $display("FAIL eop_drain got=%b exp=0", cw.wb_valid); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_ret = 64'd0;
    reset = 1'b0;
    cw.wb_ready = 1'b1;
    cw.cmt_valid = '0;
    cw.cmt_wb = '0;
    cw.cmt_eop = '0;
    cw.cmt_rd = '0;
    cw.cmt_wid = '0;
    cw.cmt_tmask = '0;
    cw.cmt_data = '0;
    cw.cmt_PC = '0;
    cw.cmt_uuid = '0;
    test_reset();
    test_single();
    test_no_wb();
    test_round_robin();
    test_reset_mid();
    test_stall();
    test_eop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_writeback.md
Name: commit_writeback

Overview:
- Receiving end of the commit interface driven by the ALU, MUL/DIV and other execute units.
- Arbitrates round-robin among NUM_REQS commit sources and registers the winner into a single writeback stage.
- Drives register-file write requests and maintains a retired-instruction counter.
- Sits between the execute units and the register file / scoreboard release path.

Parameters:
NUM_REQS, 2, number of commit sources (index 0 = ALU)
NUM_THREADS, 4, threads per warp
NW_BITS, 2, warp id width
NR_BITS, 6, register index width
UUID_BITS, 44, instruction uuid width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset (asserted when 0)
cmt_valid  input  NUM_REQS  per-source commit valid
cmt_ready  output  NUM_REQS  per-source commit accept
cmt_uuid  input  NUM_REQS*UUID_BITS  per-source uuid
cmt_wid  input  NUM_REQS*NW_BITS  per-source warp id
cmt_tmask  input  NUM_REQS*NUM_THREADS  per-source thread mask
cmt_PC  input  NUM_REQS*32  per-source PC
cmt_rd  input  NUM_REQS*NR_BITS  per-source destination register
cmt_wb  input  NUM_REQS  per-source writeback enable
cmt_eop  input  NUM_REQS  per-source end-of-packet
cmt_data  input  NUM_REQS*NUM_THREADS*32  per-source result data
wb_valid  output  1  register-file write valid
wb_ready  input  1  register-file write accept
wb_uuid  output  UUID_BITS  written instruction uuid
wb_wid  output  NW_BITS  written warp id
wb_tmask  output  NUM_THREADS  per-thread write enable
wb_PC  output  32  written instruction PC
wb_rd  output  NR_BITS  destination register
wb_data  output  NUM_THREADS*32  write data
wb_eop  output  1  end-of-packet of written entry
retired  output  64  count of retired instructions

Behaviour:
- Reset (reset==0 at posedge):
  - wb_valid=0, all wb_* data fields=0, retired=0, round-robin pointer=0.
  - cmt_ready=0 while reset is asserted.
- Stage free condition: stage_free = ~wb_valid | wb_ready.
- Arbitration (combinational):
  - Scan sources starting at the pointer, wrapping modulo NUM_REQS; the first source with cmt_valid high wins.
  - cmt_ready[i] = (i==winner) & any_valid & stage_free.
  - Every other source sees ready=0.
  - Arbitration never depends on cmt_wb.
- Accept = any_valid & stage_free. On accept:
  - Pointer <= (winner+1) mod NUM_REQS.
  - If cmt_wb[winner]=1: load the winner's fields into the output register and set wb_valid=1. Latency is 1 cycle from accept to wb_valid.
  - If cmt_wb[winner]=0: the entry is consumed without loading. wb_valid <= 0 if the current entry drains this cycle; otherwise wb_valid holds.
- No accept and wb_valid & wb_ready: wb_valid <= 0.
- Stall (wb_valid & ~wb_ready):
  - Output register holds all fields stable.
  - All cmt_ready=0, including for wb=0 entries, to preserve commit order.
- Back-to-back: a drain and a new load in the same cycle give full throughput (one writeback per cycle).
- tmask handling: wb_tmask is the accepted cmt_tmask unchanged. A zero tmask with wb=1 still produces one wb_valid beat.
- Retire counter:
  - On accept with cmt_eop[winner]=1, retired <= retired+1, regardless of cmt_wb.
  - 64-bit unsigned, wraps to 0 after all-ones.
- Pointer behaviour:
  - The pointer advances only on accept; idle cycles leave it unchanged.
  - With NUM_REQS=1 the pointer is constant 0.
- Reset mid-operation: a pending wb entry is discarded (wb_valid=0 next cycle). Sources must re-present their commits.
- Input stability: the module never drops a valid commit; sources hold valid/data until ready.

Test Plan:
- Single ALU commit (src0, wid=1, rd=5, tmask=4'b1011, data={1,2,3,4}, wb=1, eop=1), wb_ready=1 -> cmt_ready[0]=1 in cycle 0. wb_valid=1 in cycle 1 with matching fields. retired=1.
- Both sources valid continuously for 4 cycles, pointer=0 -> grant order 0,1,0,1. Four wb beats. retired=4.
- wb_ready=0 for 3 cycles while wb_valid=1 and src1 valid -> wb fields stable, cmt_ready=00 for all 3 cycles. Src1 is accepted in the cycle wb_ready returns to 1.
- Commit with wb=0, eop=1 (e.g. a branch) -> cmt_ready=1, no wb_valid beat, retired increments by 1.
- Commit with wb=1, eop=0 followed by eop=1 -> two wb beats, retired increments by 1 total.
- Reset asserted (reset=0) while wb_valid=1 and retired=7 -> next cycle wb_valid=0, retired=0, cmt_ready=0. After release, src1 alone valid -> granted immediately.
